// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_if
//  Description : Bus bundle for the multi-port register file: read ports,
//                write port, sweep-clear request/status and the debug port.
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic [NREAD-1:0]        i_RdEn;
  logic [NREAD*ADDR_W-1:0] i_RdAddr;
  logic [NREAD*DATA_W-1:0] o_RdData;
  logic                    i_WrEn;
  logic [ADDR_W-1:0]       i_WrAddr;
  logic [DATA_W-1:0]       i_WrData;
  logic                    i_ClrReq;
  logic                    o_Busy;
  logic [ADDR_W-1:0]       i_DbgAddr;
  logic [DATA_W-1:0]       o_DbgData;

  // Register-file side
  modport slave (
    input  i_RdEn, i_RdAddr, i_WrEn, i_WrAddr, i_WrData, i_ClrReq, i_DbgAddr,
    output o_RdData, o_Busy, o_DbgData
  );

  // Datapath / requester side
  modport master (
    output i_RdEn, i_RdAddr, i_WrEn, i_WrAddr, i_WrData, i_ClrReq, i_DbgAddr,
    input  o_RdData, o_Busy, o_DbgData
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-read / single-write register file with registered
//                reads, optional write-to-read bypass, optional hardwired
//                zero entry, one-entry-per-cycle sweep clear and a
//                combinational debug read port.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          Clk,
  input  logic          Rst,
  regfile_mp_if.slave   bus
);

  localparam int                c_DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_PTR_LAST = ADDR_W'(c_DEPTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [0:0]        r_state;
  logic              r_busy;
  logic [ADDR_W-1:0] r_ptr;
  logic              w_wr_ok;

  // Writes only land while idle; entry 0 is read-only when hardwired to zero
  assign w_wr_ok = bus.i_WrEn && (r_state == S_IDLE) &&
                   !((ZERO_REG != 0) && (bus.i_WrAddr == '0));

  // Sweep-clear controller: walks the pointer across every entry exactly once
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_ClrReq) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
            r_ptr   <= '0;
          end
        end
        S_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == c_PTR_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: reset zeroes everything, sweep zeroes the pointed entry
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_ok) begin
        r_mem[bus.i_WrAddr] <= bus.i_WrData;
      end
      if (r_state == S_CLEAR) begin
        r_mem[r_ptr] <= '0;
      end
    end
  end

  // One independent registered read path per port
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_val;
    logic [DATA_W-1:0] r_rd_data;

    assign w_addr = bus.i_RdAddr[k*ADDR_W +: ADDR_W];

    // Read value selection: zero entry beats bypass, bypass beats array
    always_comb begin
      w_val = r_mem[w_addr];
      if ((BYPASS != 0) && bus.i_WrEn && !r_busy && (bus.i_WrAddr == w_addr)) begin
        w_val = bus.i_WrData;
      end
      if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_val = '0;
      end
    end

    // Output register holds its value when the port is not enabled
    always_ff @(posedge Clk) begin
      if (Rst) begin
        r_rd_data <= '0;
      end else if (bus.i_RdEn[k]) begin
        r_rd_data <= w_val;
      end
    end

    assign bus.o_RdData[k*DATA_W +: DATA_W] = r_rd_data;
  end

  assign bus.o_Busy    = r_busy;
  assign bus.o_DbgData = ((ZERO_REG != 0) && (bus.i_DbgAddr == '0)) ? '0
                                                                   : r_mem[bus.i_DbgAddr];

endmodule
`default_nettype wire
